pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Sits beside the E-stage forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use,
  - taken branch/jump redirect,
  - instruction-memory not ready,
  - data-memory not ready.
- Sequences multi-cycle memory waits with an FSM.
- Tracks a pending redirect across fetch waits.
- Provides stall/flush/miss performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
Rs1D_i  in  5  rs1 of instruction in D
Rs2D_i  in  5  rs2 of instruction in D
RdE_i  in  5  rd of instruction in E
LoadE_i  in  1  instruction in E is a load
PCSrcE_i  in  1  taken branch/jump resolved in E
IMemReady_i  in  1  instruction word valid this cycle
MemReqM_i  in  1  load/store in M is accessing data memory
DMemReady_i  in  1  data memory completes access this cycle
StallF_o  out  1  hold PC
StallD_o  out  1  hold F/D register
StallE_o  out  1  hold D/E register
StallM_o  out  1  hold E/M register
FlushD_o  out  1  bubble into F/D register
FlushE_o  out  1  bubble into D/E register
FlushW_o  out  1  bubble into M/W register
FetchKill_o  out  1  discard returning instruction word (stale path)
State_o  out  2  FSM state: 0 RUN, 1 IWAIT, 2 DWAIT
StallCnt_o  out  CNT_W  cycles with StallF_o=1
FlushCnt_o  out  CNT_W  cycles with FlushE_o=1
DMissCnt_o  out  CNT_W  number of DWAIT entries

Behaviour:
- Outputs are combinational from registered state and current inputs. Counters and the FSM update on the rising edge of clk_i.
- Reset (rst_i=1, asynchronous):
  - FSM enters RUN; redirect_pend=0; all counters=0.
  - While rst_i=1: all Stall*_o=0, FlushD_o=FlushE_o=FlushW_o=1, FetchKill_o=0.
- Hazard terms:
  - dmiss = MemReqM_i & ~DMemReady_i
  - lduse = LoadE_i & (RdE_i!=0) & (RdE_i==Rs1D_i | RdE_i==Rs2D_i)
  - imiss = ~IMemReady_i
- Priority, highest first:
  1. dmiss: StallF/D/E/M=1, FlushW=1, all other flushes 0. PCSrcE_i is ignored because E is held; it applies when the stall releases.
  2. PCSrcE_i: FlushD=1, FlushE=1, no stalls.
  3. lduse: StallF=1, StallD=1, FlushE=1. Exactly one bubble, because the load leaves E next cycle.
  4. imiss: StallF=1, FlushD=1. E/M/W proceed.
  5. Otherwise all outputs 0.
- FSM:
  - RUN -> DWAIT when dmiss; else RUN -> IWAIT when imiss & ~PCSrcE_i.
  - DWAIT -> RUN when DMemReady_i=1. That cycle, stalls drop and the lower-priority terms are evaluated normally.
  - IWAIT -> DWAIT on dmiss; IWAIT -> RUN when IMemReady_i=1; otherwise stay.
  - DMissCnt_o increments on each transition into DWAIT from RUN or IWAIT.
- Redirect pending:
  - In IWAIT, PCSrcE_i=1 (outside dmiss) sets redirect_pend. The in-flight fetch is for the old path.
  - When IMemReady_i=1 with redirect_pend=1: FetchKill_o=1 and FlushD_o=1 that cycle; redirect_pend clears; FSM returns to RUN.
  - The new-path fetch then proceeds normally; if not ready, FSM re-enters IWAIT next cycle.
  - dmiss does not clear redirect_pend.
- Simultaneous events:
  - PCSrcE_i with lduse: the flush wins and no stall occurs (the D instruction is squashed).
  - PCSrcE_i with imiss in RUN: flush only, FSM stays RUN, redirect_pend is not set (no stale fetch yet).
- Counters:
  - Wrap modulo 2^CNT_W.
  - Increment in a cycle only when the corresponding output is 1 and rst_i=0.
- Reset asserted mid-wait abandons the wait immediately; the FSM is in RUN at the first edge after release.

Test Plan:
1. Load x5 in E, D reads x5 as rs2 -> one cycle StallF=StallD=1, FlushE=1, then all 0. StallCnt=1, FlushCnt=1. Same case with RdE_i=0 -> no stall.
2. MemReqM_i=1, DMemReady_i=0 for 3 cycles, then 1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, State_o=2. Returns to 0 on the ready cycle. DMissCnt=1, StallCnt=3.
3. PCSrcE_i=1 together with lduse -> FlushD=FlushE=1, StallF=0. PCSrcE_i=1 during dmiss -> only the dmiss outputs.
4. IMemReady_i=0 for 4 cycles with PCSrcE_i pulsed in cycle 2 -> FlushD/FlushE in cycle 2. On the ready cycle FetchKill_o=1, FlushD_o=1, redirect_pend cleared, State_o returns to 0.
5. Assert rst_i mid-DWAIT -> State_o=0 and all counters 0 asynchronously. Flushes are 1 while in reset. Normal operation resumes after release.
6. Preload StallCnt near 2^CNT_W-1 (CNT_W=4 build), hold imiss for 3 cycles -> counter wraps 15->0->1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Covers load-use, redirect, and instruction/data memory waits.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       RdE_i,
    input  logic             LoadE_i,
    input  logic             PCSrcE_i,
    input  logic             IMemReady_i,
    input  logic             MemReqM_i,
    input  logic             DMemReady_i,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             FlushW_o,
    output logic             FetchKill_o,
    output logic [1:0]       State_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o,
    output logic [CNT_W-1:0] DMissCnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   redirect_pend_q, redirect_pend_d;
    logic   dmiss, lduse, imiss, kill;

    assign dmiss = MemReqM_i & ~DMemReady_i;
    assign lduse = LoadE_i & (RdE_i != 5'd0) &
                   ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
    assign imiss = ~IMemReady_i;
    // Word returning after a redirect in IWAIT belongs to the old path
    assign kill  = redirect_pend_q & IMemReady_i & ~dmiss & ~rst_i;

    always_comb begin
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        FetchKill_o = 1'b0;
        if (rst_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushW_o = 1'b1;
        end else begin
            priority case (1'b1)
                dmiss: begin
                    StallF_o = 1'b1;
                    StallD_o = 1'b1;
                    StallE_o = 1'b1;
                    StallM_o = 1'b1;
                    FlushW_o = 1'b1;
                end
                PCSrcE_i: begin
                    FlushD_o = 1'b1;
                    FlushE_o = 1'b1;
                end
                lduse: begin
                    StallF_o = 1'b1;
                    StallD_o = 1'b1;
                    FlushE_o = 1'b1;
                end
                imiss: begin
                    StallF_o = 1'b1;
                    FlushD_o = 1'b1;
                end
                default: ;
            endcase
            if (kill) begin
                FetchKill_o = 1'b1;
                FlushD_o    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        unique case (state_q)
            RUN: begin
                if (dmiss)
                    state_d = DWAIT;
                else if (imiss & ~PCSrcE_i)
                    state_d = IWAIT;
            end
            IWAIT: begin
                if (dmiss)
                    state_d = DWAIT;
                else if (IMemReady_i)
                    state_d = RUN;
            end
            DWAIT: begin
                if (!dmiss)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (kill)
            redirect_pend_d = 1'b0;
        else if (state_q == IWAIT && PCSrcE_i && !dmiss && imiss)
            redirect_pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
            StallCnt_o      <= '0;
            FlushCnt_o      <= '0;
            DMissCnt_o      <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            if (StallF_o)
                StallCnt_o <= StallCnt_o + 1'b1;
            if (FlushE_o)
                FlushCnt_o <= FlushCnt_o + 1'b1;
            if (state_q != DWAIT && state_d == DWAIT)
                DMissCnt_o <= DMissCnt_o + 1'b1;
        end
    end

    assign State_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (4-bit counters to reach wrap).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       Rs1D_i, Rs2D_i, RdE_i;
    logic             LoadE_i, PCSrcE_i, IMemReady_i;
    logic             MemReqM_i, DMemReady_i;
    logic             StallF_o, StallD_o, StallE_o, StallM_o;
    logic             FlushD_o, FlushE_o, FlushW_o, FetchKill_o;
    logic [1:0]       State_o;
    logic [CNT_W-1:0] StallCnt_o, FlushCnt_o, DMissCnt_o;
    logic [7:0]       ctl;

    int checks = 0;
    int failures = 0;

    // {SF,SD,SE,SM,FD,FE,FW,Kill}
    localparam logic [7:0] C_NONE  = 8'h00;
    localparam logic [7:0] C_LDUSE = 8'hC4;
    localparam logic [7:0] C_DMISS = 8'hF2;
    localparam logic [7:0] C_BR    = 8'h0C;
    localparam logic [7:0] C_IMISS = 8'h88;
    localparam logic [7:0] C_KILL  = 8'h09;
    localparam logic [7:0] C_RST   = 8'h0E;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .RdE_i(RdE_i),
        .LoadE_i(LoadE_i), .PCSrcE_i(PCSrcE_i),
        .IMemReady_i(IMemReady_i), .MemReqM_i(MemReqM_i),
        .DMemReady_i(DMemReady_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o),
        .StallE_o(StallE_o), .StallM_o(StallM_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
        .FlushW_o(FlushW_o), .FetchKill_o(FetchKill_o),
        .State_o(State_o), .StallCnt_o(StallCnt_o),
        .FlushCnt_o(FlushCnt_o), .DMissCnt_o(DMissCnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl = {StallF_o, StallD_o, StallE_o, StallM_o,
                  FlushD_o, FlushE_o, FlushW_o, FetchKill_o};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Rs1D_i = 5'd1; Rs2D_i = 5'd2; RdE_i = 5'd3;
        LoadE_i = 1'b0; PCSrcE_i = 1'b0; IMemReady_i = 1'b1;
        MemReqM_i = 1'b0; DMemReady_i = 1'b1;
    endtask

    task automatic cyc(input string tag, input logic [7:0] ectl,
                       input logic [1:0] est);
        @(negedge clk_i);
        chk({tag, ".ctl"}, 32'(ctl), 32'(ectl));
        chk({tag, ".state"}, 32'(State_o), 32'(est));
        @(posedge clk_i);
        #1;
    endtask

    task automatic cnts(input string tag, input int s, input int f,
                        input int d);
        chk({tag, ".stallcnt"}, 32'(StallCnt_o), 32'(s));
        chk({tag, ".flushcnt"}, 32'(FlushCnt_o), 32'(f));
        chk({tag, ".dmisscnt"}, 32'(DMissCnt_o), 32'(d));
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        #1;
        chk("rst.ctl", 32'(ctl), 32'(C_RST));
        chk("rst.state", 32'(State_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        do_reset();
        cnts("rst", 0, 0, 0);

        // load-use on rs2, then one bubble only
        LoadE_i = 1'b1; RdE_i = 5'd5; Rs2D_i = 5'd5;
        cyc("lduse", C_LDUSE, 2'd0);
        LoadE_i = 1'b0;
        cyc("lduse.after", C_NONE, 2'd0);
        cnts("lduse", 1, 1, 0);
        LoadE_i = 1'b1; RdE_i = 5'd0; Rs1D_i = 5'd0; Rs2D_i = 5'd0;
        cyc("lduse.x0", C_NONE, 2'd0);
        cnts("lduse.x0", 1, 1, 0);

        // three-cycle data miss
        do_reset();
        MemReqM_i = 1'b1; DMemReady_i = 1'b0;
        cyc("dmiss1", C_DMISS, 2'd0);
        cyc("dmiss2", C_DMISS, 2'd2);
        cyc("dmiss3", C_DMISS, 2'd2);
        DMemReady_i = 1'b1;
        cyc("dmiss.rdy", C_NONE, 2'd2);
        MemReqM_i = 1'b0;
        cyc("dmiss.done", C_NONE, 2'd0);
        cnts("dmiss", 3, 0, 1);

        // redirect vs load-use, redirect under dmiss
        do_reset();
        LoadE_i = 1'b1; RdE_i = 5'd7; Rs1D_i = 5'd7; PCSrcE_i = 1'b1;
        cyc("br.lduse", C_BR, 2'd0);
        LoadE_i = 1'b0; MemReqM_i = 1'b1; DMemReady_i = 1'b0;
        cyc("br.dmiss", C_DMISS, 2'd0);
        DMemReady_i = 1'b1;
        cyc("br.release", C_BR, 2'd2);
        idle();
        cyc("br.idle", C_NONE, 2'd0);
        cnts("br", 1, 2, 1);

        // redirect during fetch wait -> stale word killed
        do_reset();
        IMemReady_i = 1'b0;
        cyc("iw1", C_IMISS, 2'd0);
        PCSrcE_i = 1'b1;
        cyc("iw2.br", C_BR, 2'd1);
        PCSrcE_i = 1'b0;
        cyc("iw3", C_IMISS, 2'd1);
        cyc("iw4", C_IMISS, 2'd1);
        IMemReady_i = 1'b1;
        cyc("iw.kill", C_KILL, 2'd1);
        cyc("iw.after", C_NONE, 2'd0);
        cnts("iw", 3, 1, 0);

        // redirect with imiss in RUN: no pending kill
        do_reset();
        IMemReady_i = 1'b0; PCSrcE_i = 1'b1;
        cyc("run.br.imiss", C_BR, 2'd0);
        IMemReady_i = 1'b1; PCSrcE_i = 1'b0;
        cyc("run.nokill", C_NONE, 2'd0);

        // reset in the middle of a data wait
        do_reset();
        MemReqM_i = 1'b1; DMemReady_i = 1'b0;
        cyc("rw1", C_DMISS, 2'd0);
        cyc("rw2", C_DMISS, 2'd2);
        rst_i = 1'b1;
        #1;
        chk("rw.state", 32'(State_o), 32'd0);
        chk("rw.ctl", 32'(ctl), 32'(C_RST));
        cnts("rw", 0, 0, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle();
        cyc("rw.resume", C_NONE, 2'd0);
        LoadE_i = 1'b1; RdE_i = 5'd9; Rs1D_i = 5'd9;
        cyc("rw.lduse", C_LDUSE, 2'd0);
        cnts("rw.resume", 1, 1, 0);

        // stall counter wrap at 4 bits
        do_reset();
        IMemReady_i = 1'b0;
        for (int i = 0; i < 15; i++)
            cyc("wrap.fill", C_IMISS, (i == 0) ? 2'd0 : 2'd1);
        chk("wrap.15", 32'(StallCnt_o), 32'd15);
        cyc("wrap.a", C_IMISS, 2'd1);
        chk("wrap.0", 32'(StallCnt_o), 32'd0);
        cyc("wrap.b", C_IMISS, 2'd1);
        chk("wrap.1", 32'(StallCnt_o), 32'd1);
        IMemReady_i = 1'b1;
        cyc("wrap.rdy", C_NONE, 2'd1);
        chk("wrap.hold", 32'(StallCnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
